fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch queue between the PC/instruction-ROM fetch stage and decode.
- Captures {pc, instr} pairs from fetch with a valid/ready handshake and buffers up to DEPTH entries in order.
- Presents the oldest entry to decode, so a decode stall backpressures fetch instead of dropping instructions.
- Supports a single-cycle flush on control-flow redirect (branch/jump resolved downstream).

Parameters:
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- in_valid  input  1  fetch offers an entry this cycle.
- in_ready  output  1  queue accepts an entry this cycle.
- in_pc  input  32  byte address of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- flush  input  1  discard all buffered entries (redirect).
- out_valid  output  1  head entry is presented to decode.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_pc  output  32  pc of the head entry.
- out_instr  output  32  instr of the head entry.
- count  output  PTR_W+1  number of entries held, 0..DEPTH.

Behaviour:
- Reset (reset==0, asynchronous)
  - wr_ptr, rd_ptr and count clear to 0; all storage entries clear to 0.
  - Consequently out_valid=0, out_pc=0x0000_0000, out_instr=0x0000_0000, and in_ready=1 once flush is low.
  - Reset release is synchronous to clk. The first push is possible on the first rising edge with reset==1.
- Handshakes
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Ready and valid generation (combinational)
  - in_ready = (count != DEPTH) & ~flush.
  - out_valid = (count != 0) & ~flush.
  - in_ready does not depend on out_ready. A full queue refuses a push even when a pop occurs in the same cycle; this keeps the fetch path free of combinational loops.
- Read path
  - out_pc and out_instr are an asynchronous read of entry rd_ptr.
  - When count==0 they hold the stale contents of that slot; decode ignores them.
- Latency
  - An entry pushed at edge N is visible at out_* with out_valid=1 after edge N. There is no bypass, so minimum latency is 1 cycle.
- Push only: entry[wr_ptr] <= {in_pc, in_instr}; wr_ptr += 1 (mod DEPTH); count += 1.
- Pop only: rd_ptr += 1 (mod DEPTH); count -= 1.
- Push and pop together (only possible when 0 < count < DEPTH): both pointers advance; count is unchanged.
- Pop at count==1 together with a push: the new entry becomes head after the edge, and out_valid stays 1.
- Pointer wrap: pointers wrap DEPTH-1 -> 0 naturally. Full and empty are distinguished by count alone, never by pointer equality.
- Flush (synchronous, highest priority)
  - In the flush cycle, in_ready=0 and out_valid=0, so no push or pop occurs.
  - At the edge: rd_ptr <= wr_ptr and count <= 0. Storage is not cleared.
  - Next cycle: in_ready=1, and the queue accepts the redirected fetch stream.
- Flush while empty or full: same behaviour; no special case.
- Reset mid-operation: all buffered entries are lost immediately. The upstream PC restarts at 0x0000_3000 independently.
- Illegal inputs: in_valid held high while in_ready=0 is legal; fetch holds its pc and instr. Data is sampled only on push.

Decomposition:
- Shared package cpu_pkg:
  - RESET_PC = 32'h0000_3000
  - NOP_INSTR = 32'h0000_0000
  - typedef fq_entry_t = {pc[31:0], instr[31:0]}
- One sub-module: fq_mem.
  - DEPTH x 64-bit register array.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - Asynchronous active-low clear.
- Pointer, count and handshake logic stays in fetch_queue.

Test Plan:
- Reset, then push pc=0x3000 instr=0x3C01_1234 (lui) at edge 1:
  - before edge 1: out_valid=0, count=0.
  - after edge 1: out_valid=1, out_pc=0x3000, out_instr=0x3C01_1234, count=1.
- Hold out_ready=0 and push 0x3000, 0x3004, 0x3008, 0x300C:
  - count=4, in_ready=0.
  - a fifth offer of 0x3010 is not accepted while in_valid stays high.
  - raise out_ready: pops come out in order 0x3000..0x300C, and 0x3010 is accepted at the cycle after the first pop.
- Continuous push and pop with in_valid=out_ready=1 for 12 cycles, pc 0x3000 step 4:
  - outputs appear in order with 1-cycle lag.
  - count stays 1.
  - pointers wrap three times with no loss or duplication.
- With count=3 (heads 0x3000, 0x3004, 0x3008), assert flush for one cycle while in_valid=1, in_pc=0x300C:
  - in the flush cycle, in_ready=0 and out_valid=0.
  - next cycle count=0, then push 0x3040: out_pc=0x3040.
- Push 0x3000 and 0x3004, then drive reset=0 asynchronously between edges:
  - out_valid=0, count=0 and out_pc=0 immediately, with no clock edge needed.
  - after release, the next push 0x3000 appears as head.
- Simultaneous push and pop at count==1 (head 0x3000, push 0x3004): after the edge, out_valid=1, out_pc=0x3004, count=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset PC, NOP encoding and the
// {pc, instr} entry carried from fetch to decode.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage : cpu_pkg

// File: rtl/fq_mem.sv
// Entry storage for the fetch queue.
// One synchronous write port, one asynchronous read port, async active-low clear.
module fq_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  fq_entry_t        wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output fq_entry_t        rdata_o
);

    fq_entry_t mem_q [DEPTH];

    // Storage array: cleared on reset, written only on an accepted push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fq_mem

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between fetch and decode, with
// valid/ready handshakes on both sides and a one-cycle redirect flush.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_s;
    logic             pop_s;
    fq_entry_t        wdata_s;
    fq_entry_t        rdata_s;

    // Ready ignores out_ready on purpose: a full queue never takes a push,
    // which keeps fetch free of a combinational path from decode.
    assign in_ready  = (count_q != FULL_CNT) & ~flush;
    assign out_valid = (count_q != '0) & ~flush;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign count     = count_q;

    assign wdata_s   = '{pc: in_pc, instr: in_instr};
    assign out_pc    = rdata_s.pc;
    assign out_instr = rdata_s.instr;

    // Pointer and occupancy next-state; flush drops everything but keeps storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [PTR_W:0]   count;

    int total = 0;
    int bad   = 0;
    logic [63:0] model_q [$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, then let the
    // edge happen and advance the model by the handshake rules.
    task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic ordy, output bit pushed);
        bit exp_ir;
        bit exp_ov;
        bit do_pop;
        @(negedge clk);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        flush     = fl;
        out_ready = ordy;
        #1;
        exp_ir = (model_q.size() != DEPTH) && !fl;
        exp_ov = (model_q.size() != 0) && !fl;
        check_eq("in_ready", 64'(in_ready), 64'(exp_ir));
        check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
        check_eq("count", 64'(count), 64'(model_q.size()));
        if (model_q.size() != 0) begin
            check_eq("head", {out_pc, out_instr}, model_q[0]);
        end
        pushed = v && exp_ir;
        do_pop = exp_ov && ordy;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (pushed) model_q.push_back({pc, ins});
        end
    endtask

    task automatic drain();
        bit p;
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, p);
        end
    endtask

    task automatic idle_check();
        bit p;
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, p);
    endtask

    initial begin
        bit          p;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        v, fl, ordy;

        reset = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_instr = 32'h0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_out_pc", 64'(out_pc), 64'd0);
        check_eq("rst_out_instr", 64'(out_instr), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;

        // First push at edge 1, then visible after it.
        tick(1'b1, RESET_PC, 32'h3C01_1234, 1'b0, 1'b0, p);
        idle_check();
        check_eq("first_push_pc", 64'(out_pc), 64'h3000);
        drain();

        // Fill with decode stalled, fifth offer held, then release decode.
        pc = RESET_PC;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, pc, pc ^ 32'hA5A5_0000, 1'b0, 1'b0, p);
            pc += 32'd4;
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, pc, pc ^ 32'hA5A5_0000, 1'b0, 1'b0, p);
            check_eq("full_refuses", 64'(p), 64'd0);
        end
        tick(1'b1, pc, pc ^ 32'hA5A5_0000, 1'b0, 1'b1, p);
        check_eq("full_pop_no_push", 64'(p), 64'd0);
        tick(1'b1, pc, pc ^ 32'hA5A5_0000, 1'b0, 1'b1, p);
        check_eq("push_after_pop", 64'(p), 64'd1);
        drain();

        // Streaming: 12 pushes with continuous pops, pointers wrap three times.
        pc = RESET_PC;
        for (int i = 0; i < 13; i++) begin
            tick(i < 12, pc, ~pc, 1'b0, 1'b1, p);
            if (p) pc += 32'd4;
        end
        check_eq("stream_pushes", 64'(pc), 64'h3030);
        drain();

        // Flush with three entries while fetch offers another.
        pc = RESET_PC;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, pc, pc + 32'h1, 1'b0, 1'b0, p);
            pc += 32'd4;
        end
        tick(1'b1, 32'h300C, 32'h1111_2222, 1'b1, 1'b1, p);
        check_eq("flush_no_push", 64'(p), 64'd0);
        tick(1'b1, 32'h3040, 32'h3333_4444, 1'b0, 1'b0, p);
        idle_check();
        check_eq("after_flush_pc", 64'(out_pc), 64'h3040);
        drain();

        // Asynchronous reset between edges.
        tick(1'b1, 32'h3000, 32'h5, 1'b0, 1'b0, p);
        tick(1'b1, 32'h3004, 32'h6, 1'b0, 1'b0, p);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_out_valid", 64'(out_valid), 64'd0);
        check_eq("async_count", 64'(count), 64'd0);
        check_eq("async_out_pc", 64'(out_pc), 64'd0);
        model_q.delete();
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1, RESET_PC, 32'h7, 1'b0, 1'b0, p);
        idle_check();

        // Push and pop together at count==1.
        tick(1'b1, 32'h3004, 32'h8, 1'b0, 1'b1, p);
        idle_check();
        check_eq("pp1_out_valid", 64'(out_valid), 64'd1);
        check_eq("pp1_out_pc", 64'(out_pc), 64'h3004);
        check_eq("pp1_count", 64'(count), 64'd1);
        drain();

        // Random traffic; fetch holds pc/instr until accepted.
        pc  = $urandom();
        ins = $urandom();
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            if (i < 100) ordy = ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            tick(v, pc, ins, fl, ordy, p);
            if (p) begin
                pc  = pc + 32'd4;
                ins = $urandom();
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_queue
